// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the multiply/divide unit state encoding.
package mips_pkg;

  localparam logic [4:0] ALU_MULTI = 5'b11010;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    RUN  = 2'd2,
    FIX  = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/mdu_step.sv
// One RUN-cycle slice: BITS_PER_CYCLE radix-2 shift-add (mult) or restoring
// trial-subtract (div) steps on unsigned magnitudes.
module mdu_step #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             is_div,
  input  logic [WIDTH:0]   hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic [WIDTH:0]   h;
  logic [WIDTH-1:0] l;
  logic [WIDTH:0]   sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   sum;

  // mult: {h,l} holds accumulator:multiplier; div: h is partial remainder, l shifts dividend out / quotient in
  always_comb begin
    h    = hi_in;
    l    = lo_in;
    sh   = '0;
    diff = '0;
    sum  = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (is_div) begin
        sh   = {h[WIDTH-1:0], l[WIDTH-1]};
        diff = sh - {1'b0, m};
        if (sh >= {1'b0, m}) begin
          h = diff;
          l = {l[WIDTH-2:0], 1'b1};
        end else begin
          h = sh;
          l = {l[WIDTH-2:0], 1'b0};
        end
      end else begin
        sum = h + (l[0] ? {1'b0, m} : '0);
        h   = {1'b0, sum[WIDTH:1]};
        l   = {sum[0], l[WIDTH-1:1]};
      end
    end
    hi_out = h;
    lo_out = l;
  end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit with architectural HI/LO for the EX stage;
// holds the pipeline through stall while a mult/div is in flight.
module mdu_iterative #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import mips_pkg::*;

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    logic signed [WIDTH-1:0] xs;
    xs = x;
    return (sgn && xs < 0) ? -x : x;
  endfunction

  function automatic logic [WIDTH-1:0] neg1(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg2(input logic [2*WIDTH-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  mdu_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             is_div;
  logic             uns;
  logic             neg_lo;
  logic             neg_hi;
  logic             dz;
  logic [WIDTH:0]   hi_w;
  logic [WIDTH-1:0] lo_w;
  logic [WIDTH-1:0] m_w;

  logic [WIDTH:0]     step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  mdu_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .is_div (is_div),
    .hi_in  (hi_w),
    .lo_in  (lo_w),
    .m      (m_w),
    .hi_out (step_hi),
    .lo_out (step_lo)
  );

  assign busy  = (state != IDLE);
  assign stall = start & busy;

  always_comb begin
    rd_data = '0;
    if (funct == FN_MFHI)      rd_data = hi;
    else if (funct == FN_MFLO) rd_data = lo;
  end

  // Sign fix-up; a zero divisor bypasses the magnitude result entirely
  always_comb begin
    prod_s = neg2({hi_w[WIDTH-1:0], lo_w}, neg_lo);
    fix_hi = prod_s[2*WIDTH-1:WIDTH];
    fix_lo = prod_s[WIDTH-1:0];
    if (is_div) begin
      if (dz) begin
        fix_hi = a_r;
        fix_lo = '1;
      end else begin
        fix_hi = neg1(hi_w[WIDTH-1:0], neg_hi);
        fix_lo = neg1(lo_w, neg_lo);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      is_div <= 1'b0;
      uns    <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      dz     <= 1'b0;
      hi_w   <= '0;
      lo_w   <= '0;
      m_w    <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            case (funct)
              FN_MTHI: hi <= a;
              FN_MTLO: lo <= a;
              FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                a_r    <= a;
                b_r    <= b;
                is_div <= funct[1];
                uns    <= funct[0];
                state  <= PREP;
              end
              default: ;
            endcase
          end
        end
        // Operands become magnitudes; MIN maps to the unsigned value 2^(WIDTH-1)
        PREP: begin
          hi_w   <= '0;
          lo_w   <= mag(a_r, ~uns);
          m_w    <= mag(b_r, ~uns);
          dz     <= (b_r == '0);
          neg_lo <= ~uns & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
          neg_hi <= ~uns & a_r[WIDTH-1];
          cnt    <= CNT_W'(N - 1);
          state  <= RUN;
        end
        RUN: begin
          hi_w <= step_hi;
          lo_w <= step_lo;
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - 1'b1;
        end
        FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Randomized plus directed checks of mdu_iterative at radix 1 and radix 4,
// both instances driven in lockstep and compared to an arithmetic model.
module tb_mdu_iterative;
  import mips_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [5:0]   funct;
  logic [W-1:0] a, b;

  logic         busy1, stall1, done1, busy4, stall4, done4;
  logic [W-1:0] rd1, hi1, lo1, rd4, hi4, lo4;

  logic [W-1:0] mhi, mlo;
  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mdu_iterative #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .funct(funct), .a(a), .b(b),
    .busy(busy1), .stall(stall1), .done(done1), .rd_data(rd1), .hi(hi1), .lo(lo1));

  mdu_iterative #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .funct(funct), .a(a), .b(b),
    .busy(busy4), .stall(stall4), .done(done4), .rd_data(rd4), .hi(hi4), .lo(lo4));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Returns {hi, lo} straight from the arithmetic definition of each op
  function automatic logic [63:0] ref_op(input logic [5:0] fn, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p  = '0;
    case (fn)
      FN_MULT:  p = 64'(sx * sy);
      FN_MULTU: p = {32'd0, x} * {32'd0, y};
      FN_DIV: begin
        if (y == 0) p = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
      FN_DIVU: begin
        if (y == 0) p = {x, 32'hFFFF_FFFF};
        else p = {x % y, x / y};
      end
      default: p = {mhi, mlo};
    endcase
    return p;
  endfunction

  task automatic do_op(input logic [5:0] fn, input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
    int nb1, nb4, nd1, nd4;
    logic [63:0] exp;
    funct = fn; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (fn inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU}) begin
      exp = ref_op(fn, x, y);
      nb1 = 0; nb4 = 0; nd1 = 0; nd4 = 0;
      for (int c = 0; c < 45; c++) begin
        if (busy1) nb1++;
        if (busy4) nb4++;
        if (done1) nd1++;
        if (done4) nd4++;
        @(negedge clk);
      end
      check({tag, "_busy1"}, 64'(nb1), 64'd34);
      check({tag, "_busy4"}, 64'(nb4), 64'd10);
      check({tag, "_done1"}, 64'(nd1), 64'd1);
      check({tag, "_done4"}, 64'(nd4), 64'd1);
      check({tag, "_hilo1"}, {hi1, lo1}, exp);
      check({tag, "_hilo4"}, {hi4, lo4}, exp);
      mhi = exp[63:32];
      mlo = exp[31:0];
    end else begin
      if (fn == FN_MTHI) mhi = x;
      if (fn == FN_MTLO) mlo = x;
      check({tag, "_busy"}, {63'd0, busy1 | busy4}, 64'd0);
      check({tag, "_hilo1"}, {hi1, lo1}, {mhi, mlo});
      check({tag, "_hilo4"}, {hi4, lo4}, {mhi, mlo});
    end
  endtask

  initial begin
    logic [W-1:0] specials [4];
    logic [5:0]   ops [4];
    logic [63:0]  exp;
    int nd;
    specials[0] = 32'h0; specials[1] = 32'hFFFF_FFFF;
    specials[2] = 32'h8000_0000; specials[3] = 32'h1;
    ops[0] = FN_MULT; ops[1] = FN_MULTU; ops[2] = FN_DIV; ops[3] = FN_DIVU;
    mhi = '0; mlo = '0;
    reset = 1'b1; start = 1'b0; funct = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_state", {hi1, lo1, 30'd0, busy1, done1}, 96'd0);
    check("rst_state4", {hi4, lo4, 30'd0, busy4, done4}, 96'd0);
    reset = 1'b0;
    @(negedge clk);

    do_op(FN_MULT, 32'hFFFF_FFFD, 32'd7, "t1");
    check("t1_lit", {hi1, lo1}, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "t2");
    check("t2_lit", {hi4, lo4}, 64'hFFFF_FFFE_0000_0001);
    funct = FN_MFHI; start = 1'b1; #1;
    check("t2_mfhi", {rd1, rd4}, {mhi, mhi});
    @(negedge clk);
    start = 1'b0;
    do_op(FN_DIV, 32'hFFFF_FFF9, 32'd2, "t3a");
    check("t3a_lit", {hi1, lo1}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(FN_DIVU, 32'd7, 32'd2, "t3b");
    do_op(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "t3c");
    check("t3c_lit", {hi4, lo4}, 64'h0000_0000_8000_0000);
    do_op(FN_DIV, 32'd5, 32'd0, "t4");
    check("t4_lit", {hi1, lo1}, 64'h0000_0005_FFFF_FFFF);
    do_op(FN_DIVU, 32'h8000_0001, 32'd0, "t4u");

    // start held while busy: stall until the done cycle, where mflo sees the new LO
    exp = ref_op(FN_MULT, 32'd1234567, 32'hFFFF_F000);
    funct = FN_MULT; a = 32'd1234567; b = 32'hFFFF_F000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    funct = FN_MFLO; start = 1'b1;
    for (int k = 5; k <= 35; k++) begin
      #1;
      if (k == 5 || k == 20 || k == 34 || k == 35)
        check($sformatf("t5_stall_c%0d", k), {63'd0, stall1}, {63'd0, k <= 34});
      if (k == 35) begin
        check("t5_done", {63'd0, done1}, 64'd1);
        check("t5_mflo", {32'd0, rd1}, {32'd0, exp[31:0]});
      end
      @(negedge clk);
    end
    start = 1'b0;
    mhi = exp[63:32]; mlo = exp[31:0];
    repeat (3) @(negedge clk);
    check("t5_hilo4", {hi4, lo4}, exp);
    do_op(FN_MTLO, 32'h1234, 32'd0, "t5_mtlo");
    do_op(FN_MTHI, 32'hCAFE_0001, 32'd0, "t5_mthi");
    do_op(6'h20, 32'hDEAD_BEEF, 32'd3, "unk");

    // asynchronous reset mid-op
    funct = FN_MULT; a = 32'd99; b = 32'd77; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1; #1;
    check("t6_rst", {hi1, lo1, 31'd0, busy1}, 96'd0);
    check("t6_rst4", {hi4, lo4, 31'd0, busy4}, 96'd0);
    @(negedge clk);
    reset = 1'b0;
    mhi = '0; mlo = '0;
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      if (done1 || done4 || busy1 || busy4) nd++;
      @(negedge clk);
    end
    check("t6_quiet", 64'(nd), 64'd0);
    do_op(FN_MULT, 32'd6, 32'd7, "t6_mult");
    check("t6_lit", {32'd0, lo1}, 64'd42);

    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] x, y;
      logic [5:0]   fn;
      fn = ops[$urandom_range(0, 3)];
      x  = ($urandom_range(0, 5) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      y  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      if ($urandom_range(0, 2) == 0) y = y >> $urandom_range(8, 28);
      do_op(fn, x, y, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
